// File: rtl/running_avg_filter_if.sv
// running_avg_filter_if: codec capture/playback handshake and filtered result bundle
interface running_avg_filter_if #(parameter int WIDTH = 24);
    logic [WIDTH-1:0] in;
    logic             read_ready;
    logic             write_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             overrun;
    modport master (output in, read_ready, write_ready, input out, out_valid, overrun);
    modport slave  (input in, read_ready, write_ready, output out, out_valid, overrun);
endinterface

// File: rtl/running_avg_filter.sv
// running_avg_filter: per-channel N-tap boxcar average of signed codec samples
module running_avg_filter #(
    parameter int WIDTH = 24,
    parameter int LOG2N = 4
) (
    input logic                  clk,
    input logic                  reset,
    running_avg_filter_if.slave  bus
);
    localparam int AW = WIDTH + LOG2N;
    localparam logic [LOG2N:0] FULL = (LOG2N + 1)'(1 << LOG2N);
    logic [WIDTH-1:0] hist [1 << LOG2N];
    logic [LOG2N-1:0] wptr;
    logic [LOG2N:0]   fill;
    logic [AW-1:0]    acc, acc_next;
    logic [WIDTH-1:0] oldest;
    logic             accept;
    // oldest is zero until the window has filled, so stale history never leaks out
    always_comb begin
        accept   = bus.read_ready && !reset;
        oldest   = (fill == FULL) ? hist[wptr] : '0;
        acc_next = acc + {{LOG2N{bus.in[WIDTH-1]}}, bus.in} - {{LOG2N{oldest[WIDTH-1]}}, oldest};
    end
    // history buffer keeps its contents across reset
    always_ff @(posedge clk) begin
        if (accept) hist[wptr] <= bus.in;
    end
    // accumulator, pointers and the shifted (floor) average
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            wptr    <= '0;
            fill    <= '0;
            bus.out <= '0;
        end else if (bus.read_ready) begin
            acc     <= acc_next;
            wptr    <= wptr + 1'b1;
            fill    <= (fill == FULL) ? FULL : fill + 1'b1;
            bus.out <= acc_next[AW-1:LOG2N];
        end
    end
    // result-pending flag and sticky overrun when an unconsumed result is replaced
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.out_valid <= bus.read_ready ? 1'b1 : (bus.write_ready ? 1'b0 : bus.out_valid);
            bus.overrun   <= bus.overrun || (bus.read_ready && bus.out_valid && !bus.write_ready);
        end
    end
endmodule
